crc32_frame_checker: RTL and testbench

- Receive-side counterpart of the team's CRC-32 frame generator.
- Accepts a byte stream carrying frames laid out as {message bytes, 32-bit CRC}, MSB first, through a valid/ready handshake.
- Divides each frame bit-serially by the CRC-32 polynomial and reports pass/fail, the recovered message and the received CRC.
- Sits between the link byte deserializer and the message consumer/7-segment display logic.

---
 rtl/crc32_frame_checker.sv | 147 ++++++++++++++
 tb/tb_crc32_frame_checker.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/crc32_frame_checker.sv
// -----------------------------------------------------------------------------
// crc32_frame_checker
//
// Receive-side CRC-32 checker. Accepts frames laid out as
// {MSG_BYTES message bytes, 4 CRC bytes}, MSB first, one byte per valid/ready
// transfer. Each frame bit is divided serially by the generator polynomial
// (init 0, no reflection, no final XOR). A frame whose remainder is zero after
// all of its bits passes.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous, active-high reset
//   in_data   frame byte, MSB transmitted first
//   in_valid  in_data valid
//   in_sof    in_data is the first byte of a frame
//   in_ready  checker can accept a byte this cycle
//   msg_out   recovered message of the last completed frame, first byte in MSBs
//   crc_rx    received CRC field of the last completed frame
//   done      one-cycle pulse, frame check complete
//   flag      2'b10 pass, 2'b01 fail, 2'b00 no result yet
//   busy      frame in progress
// -----------------------------------------------------------------------------
module crc32_frame_checker #(
  parameter int          MSG_BYTES = 1,
  parameter logic [31:0] POLY      = 32'h04C11DB7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  input  logic                   in_sof,
  output logic                   in_ready,
  output logic [8*MSG_BYTES-1:0] msg_out,
  output logic [31:0]            crc_rx,
  output logic                   done,
  output logic [1:0]             flag,
  output logic                   busy
);

  localparam int FRAME_BYTES = MSG_BYTES + 4;
  localparam int IDX_W       = $clog2(FRAME_BYTES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                 state, state_next;
  logic [31:0]            rem, rem_next;
  logic [7:0]             shreg;
  logic [2:0]             bit_cnt;
  logic [IDX_W-1:0]       byte_idx, idx_next;
  logic [8*MSG_BYTES-1:0] msg_stage;
  logic [31:0]            crc_stage;
  logic                   accept, load, last_byte, last_bit;

  assign accept    = in_valid && in_ready;
  // In IDLE only an SOF byte starts a frame; in WAIT every byte is taken,
  // and an SOF there abandons the current frame and restarts at byte 0.
  assign load      = accept && ((state == S_WAIT) || in_sof);
  assign idx_next  = in_sof ? '0 : byte_idx + 1'b1;
  assign last_byte = (byte_idx == IDX_W'(FRAME_BYTES - 1));
  assign last_bit  = (bit_cnt == 3'd7);

  // One step of polynomial long division: bring in the next frame bit and
  // subtract (XOR) the generator whenever the x^32 term would overflow.
  assign rem_next = {rem[30:0], shreg[7]} ^ (rem[31] ? POLY : 32'h0);

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking assignments here would create ordering races.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state and handshake outputs.
  // NOTE: every output of this block gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b1;
    unique case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid && in_sof) state_next = S_SHIFT;
      end
      S_SHIFT: begin
        if (last_bit) state_next = last_byte ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        in_ready = 1'b1;
        if (in_valid) state_next = S_SHIFT;
      end
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: byte latch, bit divider, staging and result registers.
  // NOTE: these are plain registers, not a memory array, so all of them take
  // the documented reset values; nothing is left to power-up state.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem       <= '0;
      shreg     <= '0;
      bit_cnt   <= '0;
      byte_idx  <= '0;
      msg_stage <= '0;
      crc_stage <= '0;
      msg_out   <= '0;
      crc_rx    <= '0;
      done      <= 1'b0;
      flag      <= 2'b00;
    end else begin
      done <= 1'b0;
      if (load) begin
        shreg    <= in_data;
        bit_cnt  <= '0;
        byte_idx <= idx_next;
        if (in_sof) rem <= '0;
        // Message bytes land in fixed slots; CRC bytes shift in MSB first.
        for (int i = 0; i < MSG_BYTES; i++) begin
          if (idx_next == IDX_W'(i)) msg_stage[(MSG_BYTES-1-i)*8 +: 8] <= in_data;
        end
        if (idx_next >= IDX_W'(MSG_BYTES)) crc_stage <= {crc_stage[23:0], in_data};
      end else if (state == S_SHIFT) begin
        rem     <= rem_next;
        shreg   <= {shreg[6:0], 1'b0};
        bit_cnt <= bit_cnt + 3'd1;
        // Results are taken from the final remainder on the edge that
        // enters DONE, so they appear together with the done pulse.
        if (last_bit && last_byte) begin
          done    <= 1'b1;
          flag    <= (rem_next == 32'h0) ? 2'b10 : 2'b01;
          msg_out <= msg_stage;
          crc_rx  <= crc_stage;
        end
      end
    end
  end

endmodule

// File: tb/tb_crc32_frame_checker.sv
// -----------------------------------------------------------------------------
// tb_crc32_frame_checker
//
// Self-checking bench for crc32_frame_checker (MSG_BYTES=1). Directed frames
// come from a vector table; corner cases (stray byte, abandoned frame, reset
// mid-frame, gapped valid) are hand-written sequences; random frames are
// checked against a reference that computes the CRC of the message and
// compares it with the received field.
// -----------------------------------------------------------------------------
module tb_crc32_frame_checker;

  localparam int          MB     = 1;
  localparam int          FB     = MB + 4;
  localparam logic [31:0] POLY   = 32'h04C11DB7;
  localparam time         PERIOD = 10;

  logic            clk;
  logic            rst;
  logic [7:0]      in_data;
  logic            in_valid;
  logic            in_sof;
  logic            in_ready;
  logic [8*MB-1:0] msg_out;
  logic [31:0]     crc_rx;
  logic            done;
  logic [1:0]      flag;
  logic            busy;

  crc32_frame_checker #(.MSG_BYTES(MB), .POLY(POLY)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_sof   (in_sof),
    .in_ready (in_ready),
    .msg_out  (msg_out),
    .crc_rx   (crc_rx),
    .done     (done),
    .flag     (flag),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #(PERIOD/2) clk = ~clk;

  int  checks = 0;
  int  errors = 0;
  int  done_cnt = 0;
  int  pulse_err = 0;
  time done_t = 0;
  time last_acc_t = 0;
  logic prev_done = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // done monitor: count pulses, remember when the last one was seen, and
  // flag any pulse wider than one cycle.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      done_t = $time;
      if (prev_done === 1'b1) pulse_err++;
    end
    prev_done = done;
  end

  // Reference: CRC of the message as remainder of M(x)*x^32 mod G(x).
  function automatic logic [31:0] crc_model(input logic [8*MB-1:0] m);
    logic [31:0] c = 32'h0;
    for (int k = 0; k < MB; k++) begin
      c ^= {m[8*(MB-1-k) +: 8], 24'h0};
      for (int j = 0; j < 8; j++) c = c[31] ? ((c << 1) ^ POLY) : (c << 1);
    end
    return c;
  endfunction

  // Present one byte at a negedge and keep presenting until in_ready is high
  // (the transfer then happens at the next rising edge).
  task automatic send_byte(input logic [7:0] d, input logic s, input int gap);
    bit ok = 1'b0;
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      in_sof   = s;
      if (in_ready) begin
        ok = 1'b1;
        last_acc_t = $time;
      end
    end
    check("byte_accepted", 64'(ok), 64'd1);
  endtask

  task automatic drop_valid();
    @(negedge clk);
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send_frame(input logic [8*FB-1:0] f, input int maxgap);
    for (int k = 0; k < FB; k++)
      send_byte(f[8*(FB-1-k) +: 8], (k == 0), (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    drop_valid();
  endtask

  // Wait (bounded) for one done pulse after 'base', then confirm exactly one
  // occurred, its latency, and the result registers.
  task automatic expect_result(input string name, input int base, input logic [1:0] f_exp,
                               input logic [8*MB-1:0] m_exp, input logic [31:0] c_exp);
    for (int i = 0; i < 60 && done_cnt == base; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    check({name, "_done_count"}, 64'(done_cnt - base), 64'd1);
    check({name, "_latency"}, 64'(done_t - last_acc_t), 64'(9 * PERIOD));
    check({name, "_flag"}, 64'(flag), 64'(f_exp));
    check({name, "_msg"}, 64'(msg_out), 64'(m_exp));
    check({name, "_crc"}, 64'(crc_rx), 64'(c_exp));
  endtask

  typedef struct packed {
    logic [8*FB-1:0] frame;
    logic [8*MB-1:0] msg;
    logic [31:0]     crc;
    logic [1:0]      flg;
  } vec_t;

  vec_t tbl [4];

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation timeout");
  end

  initial begin
    int   base;
    bit   busy_seen;
    logic [7:0]  m;
    logic [31:0] c;
    logic [1:0]  fexp;

    tbl[0] = '{frame: 40'h01_04C11DB7, msg: 8'h01, crc: 32'h04C11DB7, flg: 2'b10};
    tbl[1] = '{frame: 40'h02_09823B6E, msg: 8'h02, crc: 32'h09823B6E, flg: 2'b10};
    tbl[2] = '{frame: 40'h02_09823B6F, msg: 8'h02, crc: 32'h09823B6F, flg: 2'b01};
    tbl[3] = '{frame: 40'h00_00000000, msg: 8'h00, crc: 32'h00000000, flg: 2'b10};

    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_flag", 64'(flag), 64'd0);
    check("reset_msg", 64'(msg_out), 64'd0);
    check("reset_crc", 64'(crc_rx), 64'd0);
    rst = 1'b0;

    // Directed frames with in_valid held high across each frame.
    for (int v = 0; v < 4; v++) begin
      base = done_cnt;
      send_frame(tbl[v].frame, 0);
      expect_result($sformatf("vec%0d", v), base, tbl[v].flg, tbl[v].msg, tbl[v].crc);
    end

    // Stray non-SOF byte in IDLE: taken and dropped, nothing starts.
    base = done_cnt;
    busy_seen = 1'b0;
    send_byte(8'h55, 1'b0, 0);
    drop_valid();
    repeat (20) begin
      @(negedge clk);
      busy_seen |= busy;
    end
    check("stray_busy", 64'(busy_seen), 64'd0);
    check("stray_no_done", 64'(done_cnt - base), 64'd0);

    // SOF arriving in WAIT abandons the partial frame.
    base = done_cnt;
    send_byte(8'h01, 1'b1, 0);
    send_byte(8'h04, 1'b0, 0);
    send_byte(8'hC1, 1'b0, 0);
    send_frame(40'h02_09823B6E, 0);
    expect_result("abandon", base, 2'b10, 8'h02, 32'h09823B6E);

    // Reset during the SHIFT of byte 3 discards the frame.
    base = done_cnt;
    send_byte(8'h01, 1'b1, 0);
    send_byte(8'h04, 1'b0, 0);
    send_byte(8'hC1, 1'b0, 0);
    send_byte(8'h1D, 1'b0, 0);
    drop_valid();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_flag", 64'(flag), 64'd0);
    check("midrst_msg", 64'(msg_out), 64'd0);
    check("midrst_crc", 64'(crc_rx), 64'd0);
    repeat (20) @(posedge clk);
    check("midrst_no_done", 64'(done_cnt - base), 64'd0);
    base = done_cnt;
    send_frame(40'h01_04C11DB7, 0);
    expect_result("after_rst", base, 2'b10, 8'h01, 32'h04C11DB7);

    // Same frame with random idle gaps between bytes.
    base = done_cnt;
    send_frame(40'h01_04C11DB7, 20);
    expect_result("gapped", base, 2'b10, 8'h01, 32'h04C11DB7);

    // Random frames against the reference model, about half corrupted.
    for (int r = 0; r < 40; r++) begin
      m = 8'($urandom);
      c = crc_model(m);
      if ($urandom_range(0, 1) == 1) c ^= 32'h1 << $urandom_range(0, 31);
      fexp = (c == crc_model(m)) ? 2'b10 : 2'b01;
      base = done_cnt;
      send_frame({m, c}, 3);
      expect_result($sformatf("rand%0d", r), base, fexp, m, c);
    end

    check("done_single_cycle", 64'(pulse_err), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
